// File: rtl/grad_spi_tx_pkg.sv
// rtl/grad_spi_tx_pkg.sv - shared defaults, state encoding and divisor helper for grad_spi_tx
package grad_spi_tx_pkg;
  localparam int DATA_BITS_DEF = 24;
  localparam int CHANNELS_DEF  = 4;
  localparam int DIV_W         = 6;
  localparam int HALF_W        = DIV_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_HOLD  = 3'd2,
    ST_LDAC  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Half-period length in clk cycles; one extra bit so a divisor of 63 gives 64.
  function automatic logic [HALF_W-1:0] half_period(input logic [DIV_W-1:0] div);
    return {1'b0, div} + HALF_W'(1);
  endfunction
endpackage

// File: rtl/grad_spi_tx_if.sv
// rtl/grad_spi_tx_if.sv - word/strobe/status bundle between grad_bram and grad_spi_tx
interface grad_spi_tx_if #(
  parameter int CHANNELS = 4
);
  import grad_spi_tx_pkg::*;

  logic [31:0]          data_i;
  logic [CHANNELS-1:0]  valid_i;
  logic [DIV_W-1:0]     spi_clk_div_i;
  logic                 busy_o;
  logic                 data_lost_o;

  modport master (
    output data_i, valid_i, spi_clk_div_i,
    input  busy_o, data_lost_o
  );

  modport slave (
    input  data_i, valid_i, spi_clk_div_i,
    output busy_o, data_lost_o
  );
endinterface

// File: rtl/grad_spi_tx_tick.sv
// rtl/grad_spi_tx_tick.sv - loadable half-period counter, one-cycle tick every H enabled cycles
module grad_spi_tick
  import grad_spi_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_en,
  input  logic [HALF_W-1:0] i_half,
  output logic              o_tick
);
  logic [HALF_W-1:0] r_half;
  logic [HALF_W-1:0] r_cnt;
  logic              w_last;

  assign w_last = (r_cnt == (r_half - HALF_W'(1)));
  assign o_tick = i_en & w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_half <= HALF_W'(1);
      r_cnt  <= '0;
    end else if (i_load) begin
      r_half <= i_half;
      r_cnt  <= '0;
    end else if (i_en) begin
      r_cnt  <= w_last ? '0 : r_cnt + HALF_W'(1);
    end
  end
endmodule

// File: rtl/grad_spi_tx.sv
// rtl/grad_spi_tx.sv - four-lane SPI DAC serialiser with shared SCLK, per-lane SYNC and common LDAC
module grad_spi_tx
  import grad_spi_tx_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CHANNELS  = CHANNELS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  grad_spi_tx_if.slave        bram,
  output logic                sclk_o,
  output logic [CHANNELS-1:0] sync_n_o,
  output logic [CHANNELS-1:0] sdo_o,
  output logic                ldac_n_o
);
  localparam int                HP_W    = $clog2(2 * DATA_BITS);
  localparam logic [HP_W-1:0]   HP_LAST = HP_W'(2 * DATA_BITS - 1);

  state_t                r_state, w_state_nxt;
  logic [HP_W-1:0]       r_hp, w_hp_nxt;
  logic [DATA_BITS-1:0]  r_shreg, w_shreg_nxt;
  logic [CHANNELS-1:0]   r_mask, w_mask_nxt;
  logic                  w_strobe, w_accept, w_tick;

  logic                  r_sclk, w_sclk_nxt;
  logic [CHANNELS-1:0]   r_sync_n, w_sync_n_nxt;
  logic [CHANNELS-1:0]   r_sdo, w_sdo_nxt;
  logic                  r_ldac_n, w_ldac_n_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_lost, w_lost_nxt;
  logic                  w_unused_hi;

  assign w_unused_hi = ^bram.data_i[31:DATA_BITS];
  assign w_strobe    = |bram.valid_i;
  assign w_accept    = (r_state == ST_IDLE) && w_strobe;

  grad_spi_tick u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_accept),
    .i_en   (r_state != ST_IDLE),
    .i_half (half_period(bram.spi_clk_div_i)),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_strobe) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_tick && (r_hp == HP_LAST)) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_tick) w_state_nxt = ST_LDAC;
      ST_LDAC:  if (w_tick) w_state_nxt = ST_GAP;
      ST_GAP:   if (w_tick) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Even half-periods have SCLK high; the payload advances on each odd->even step (SCLK rise).
  always_comb begin
    w_hp_nxt    = r_hp;
    w_shreg_nxt = r_shreg;
    w_mask_nxt  = r_mask;
    if (w_accept) begin
      w_hp_nxt    = '0;
      w_shreg_nxt = bram.data_i[DATA_BITS-1:0];
      w_mask_nxt  = bram.valid_i;
    end else if ((r_state == ST_SHIFT) && w_tick) begin
      w_hp_nxt = r_hp + HP_W'(1);
      if (r_hp[0]) w_shreg_nxt = {r_shreg[DATA_BITS-2:0], 1'b0};
    end
  end

  always_comb begin
    w_sclk_nxt   = 1'b1;
    w_sync_n_nxt = '1;
    w_sdo_nxt    = '0;
    w_ldac_n_nxt = 1'b1;
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_lost_nxt   = r_busy & w_strobe;
    case (w_state_nxt)
      ST_SHIFT: begin
        w_sclk_nxt   = ~w_hp_nxt[0];
        w_sync_n_nxt = ~w_mask_nxt;
        w_sdo_nxt    = {CHANNELS{w_shreg_nxt[DATA_BITS-1]}} & w_mask_nxt;
      end
      ST_HOLD:  w_sync_n_nxt = ~w_mask_nxt;
      ST_LDAC:  w_ldac_n_nxt = 1'b0;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hp     <= '0;
      r_shreg  <= '0;
      r_mask   <= '0;
      r_sclk   <= 1'b1;
      r_sync_n <= '1;
      r_sdo    <= '0;
      r_ldac_n <= 1'b1;
      r_busy   <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_hp     <= w_hp_nxt;
      r_shreg  <= w_shreg_nxt;
      r_mask   <= w_mask_nxt;
      r_sclk   <= w_sclk_nxt;
      r_sync_n <= w_sync_n_nxt;
      r_sdo    <= w_sdo_nxt;
      r_ldac_n <= w_ldac_n_nxt;
      r_busy   <= w_busy_nxt;
      r_lost   <= w_lost_nxt;
    end
  end

  assign sclk_o           = r_sclk;
  assign sync_n_o         = r_sync_n;
  assign sdo_o            = r_sdo;
  assign ldac_n_o         = r_ldac_n;
  assign bram.busy_o      = r_busy;
  assign bram.data_lost_o = r_lost;
endmodule

// File: tb/tb_grad_spi_tx.sv
// tb/tb_grad_spi_tx.sv - scoreboard bench for grad_spi_tx against a frame-level model
module tb_grad_spi_tx;
  import grad_spi_tx_pkg::*;

  localparam int DB       = 24;
  localparam int CH       = 4;
  localparam int FRAME_HP = 2 * DB + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sclk;
  logic [CH-1:0] sync_n;
  logic [CH-1:0] sdo;
  logic          ldac_n;

  grad_spi_tx_if #(.CHANNELS(CH)) bram_if ();

  grad_spi_tx #(.DATA_BITS(DB), .CHANNELS(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bram     (bram_if),
    .sclk_o   (sclk),
    .sync_n_o (sync_n),
    .sdo_o    (sdo),
    .ldac_n_o (ldac_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            start;
    logic [DB-1:0] data;
    logic [CH-1:0] mask;
    int            h;
  } frame_t;

  frame_t frame_q[$];
  int     lost_q[$];
  int     edge_cnt  = 0;
  int     free_edge = 0;
  int     n_vec     = 0;
  int     n_miss    = 0;
  bit     expect_abort = 1'b0;
  bit     in_frame     = 1'b0;

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic check_reset_values();
    check("rst_sclk",   sclk,                1);
    check("rst_sync_n", sync_n,              {CH{1'b1}});
    check("rst_sdo",    sdo,                 0);
    check("rst_ldac_n", ldac_n,              1);
    check("rst_busy",   bram_if.busy_o,      0);
    check("rst_lost",   bram_if.data_lost_o, 0);
  endtask

  // Called on a falling clk edge; the strobe is sampled at the next rising edge.
  task automatic issue(input logic [31:0] d, input logic [CH-1:0] v, input logic [5:0] div);
    frame_t f;
    int     m;
    m = edge_cnt + 1;
    bram_if.data_i        = d;
    bram_if.valid_i       = v;
    bram_if.spi_clk_div_i = div;
    if (v != '0) begin
      if (m >= free_edge) begin
        f.start = m;
        f.data  = d[DB-1:0];
        f.mask  = v;
        f.h     = int'(div) + 1;
        frame_q.push_back(f);
        free_edge = m + FRAME_HP * f.h + 1;
      end else begin
        lost_q.push_back(m);
      end
    end
    @(negedge clk);
    bram_if.valid_i = '0;
  endtask

  task automatic wait_to(input int e);
    while (edge_cnt + 1 < e) @(negedge clk);
  endtask

  // Frame monitor: opens a record on busy rise, compares on busy fall.
  initial begin
    frame_t        cur;
    bit            have;
    int            busy_cnt, falls, ldac_cnt, sync_cnt, viol, first_fall;
    logic [DB-1:0] got [CH];
    logic          prev_sclk;
    prev_sclk = 1'b1;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!in_frame && bram_if.busy_o === 1'b1) begin
        in_frame = 1'b1;
        busy_cnt = 0; falls = 0; ldac_cnt = 0; sync_cnt = 0; viol = 0; first_fall = -1;
        for (int l = 0; l < CH; l++) got[l] = '0;
        have = (frame_q.size() != 0);
        if (have) begin
          cur = frame_q.pop_front();
          check("start_edge", edge_cnt, cur.start);
        end else begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_frame: got frame at edge %0d expected none", edge_cnt);
        end
      end
      if (in_frame) begin
        if (bram_if.busy_o === 1'b1) begin
          busy_cnt++;
          if (prev_sclk === 1'b1 && sclk === 1'b0) begin
            if (falls == 0) first_fall = edge_cnt;
            falls++;
            for (int l = 0; l < CH; l++) got[l] = {got[l][DB-2:0], sdo[l]};
          end
          if (have) begin
            if (ldac_n === 1'b0) begin
              ldac_cnt++;
              if (sync_n !== {CH{1'b1}}) viol++;
            end
            if (sync_n === ~cur.mask) sync_cnt++;
            if (((~sync_n | sdo) & ~cur.mask) != '0) viol++;
          end
        end else begin
          in_frame = 1'b0;
          if (expect_abort) begin
            check("abort_ldac_cycles", ldac_cnt, 0);
            expect_abort = 1'b0;
          end else if (have) begin
            check("busy_cycles",      busy_cnt,               FRAME_HP * cur.h);
            check("sclk_falls",       falls,                  DB);
            check("first_fall_delay", first_fall - cur.start, cur.h);
            check("ldac_cycles",      ldac_cnt,               cur.h);
            check("sync_low_cycles",  sync_cnt,               (2 * DB + 1) * cur.h);
            check("idle_lane_viol",   viol,                   0);
            for (int l = 0; l < CH; l++)
              check($sformatf("lane%0d_data", l), got[l], cur.mask[l] ? cur.data : '0);
          end
        end
      end
      prev_sclk = sclk;
    end
  end

  initial forever begin
    @(negedge clk);
    if (bram_if.data_lost_o === 1'b1) begin
      if (lost_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_lost: got pulse at edge %0d expected none", edge_cnt);
      end else begin
        check("lost_edge", edge_cnt, lost_q.pop_front());
      end
    end
  end

  initial begin
    int mode;
    bram_if.data_i        = '0;
    bram_if.valid_i       = '0;
    bram_if.spi_clk_div_i = '0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    issue(32'h00ABCDEF, 4'b1111, 6'd3);
    wait_to(free_edge);

    issue($urandom, 4'b0101, 6'd2);
    wait_to(free_edge);

    issue($urandom, 4'b1111, 6'd1);
    repeat (9) @(negedge clk);
    issue($urandom, 4'b1111, 6'd1);
    wait_to(free_edge);

    issue($urandom, 4'b0011, 6'd1);
    wait_to(free_edge - 1);
    issue($urandom, 4'b1100, 6'd1);
    issue($urandom, 4'b1010, 6'd1);
    wait_to(free_edge);

    issue($urandom, 4'b1111, 6'd30);
    repeat (100) @(negedge clk);
    bram_if.spi_clk_div_i = 6'd0;
    wait_to(free_edge);
    issue($urandom, 4'b1111, 6'd0);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      if (mode == 1) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
      end else begin
        wait_to(free_edge);
        if (mode >= 2) repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      issue($urandom, 4'($urandom_range(1, 15)), 6'($urandom_range(0, 7)));
    end

    wait_to(free_edge);
    issue($urandom, 4'b1111, 6'd2);
    repeat (30) @(negedge clk);
    expect_abort = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    free_edge = 0;
    issue($urandom, 4'b0110, 6'd0);
    wait_to(free_edge);

    repeat (5) @(negedge clk);
    check("frames_pending", frame_q.size(), 0);
    check("lost_pending",   lost_q.size(),  0);
    check("frame_open",     in_frame,       0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
